// File: rtl/lane_car_counter.sv
// lane_car_counter: multi-lane vehicle counter. Each detector lane passes
// through a two-flop synchroniser and a debounce filter. Every accepted rising
// edge pulses lane_event. When enabled, it also bumps that lane's
// modulo-MAX_COUNT tally and the combined total. All outputs are registered.
module lane_car_counter #(
  parameter int N_LANES    = 4,
  parameter int CNT_W      = 14,
  parameter int MAX_COUNT  = 10000,
  parameter int DEB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [N_LANES-1:0]       detector,
  output logic [N_LANES*CNT_W-1:0] count,
  output logic [CNT_W-1:0]         total,
  output logic [N_LANES-1:0]       lane_event,
  output logic [N_LANES-1:0]       wrap,
  output logic                     total_wrap
);

  localparam int DC_W  = $clog2(DEB_CYCLES) + 1;
  localparam int SUM_W = CNT_W + 1;

  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);
  localparam logic [SUM_W-1:0] SUM_MAX  = SUM_W'(MAX_COUNT);

  logic [N_LANES-1:0] s1_q, s1_d;
  logic [N_LANES-1:0] s2_q, s2_d;
  logic [N_LANES-1:0] deb_q, deb_d;
  logic [DC_W-1:0]    dc_q [N_LANES];
  logic [DC_W-1:0]    dc_d [N_LANES];
  logic [CNT_W-1:0]   count_q [N_LANES];
  logic [CNT_W-1:0]   count_d [N_LANES];
  logic [CNT_W-1:0]   total_q, total_d;
  logic [N_LANES-1:0] event_q, event_d;
  logic [N_LANES-1:0] wrap_q, wrap_d;
  logic               total_wrap_q, total_wrap_d;

  logic [N_LANES-1:0] rise;
  logic [SUM_W-1:0]   inc;
  logic [SUM_W-1:0]   sum;

  // Two-stage synchroniser shift: raw level into s1, s1 into s2.
  always_comb begin
    s1_d = detector;
    s2_d = s1_q;
  end

  // Debounce: a flip needs DEB_CYCLES consecutive s2 samples that differ from
  // deb. Only a flip to 1 is counted as a rise.
  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      dc_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (dc_q[i] == DC_LAST) begin
          deb_d[i] = s2_q[i];
          rise[i]  = s2_q[i];
        end else begin
          dc_d[i] = dc_q[i] + 1'b1;
        end
      end
    end
  end

  // Lane tallies, total and flags. The total sum is one bit wider than a
  // count so that adding up to N_LANES cannot overflow. clr wins over any
  // increment in the same cycle.
  always_comb begin
    event_d      = rise;
    wrap_d       = '0;
    total_wrap_d = 1'b0;
    inc          = '0;
    for (int i = 0; i < N_LANES; i++) begin
      count_d[i] = count_q[i];
      if (en && rise[i]) begin
        inc = inc + SUM_W'(1);
        if (count_q[i] == CNT_LAST) begin
          count_d[i] = '0;
          wrap_d[i]  = 1'b1;
        end else begin
          count_d[i] = count_q[i] + 1'b1;
        end
      end
    end
    sum = {1'b0, total_q} + inc;
    if (sum >= SUM_MAX) begin
      total_d      = CNT_W'(sum - SUM_MAX);
      total_wrap_d = 1'b1;
    end else begin
      total_d = sum[CNT_W-1:0];
    end
    if (clr) begin
      for (int i = 0; i < N_LANES; i++) begin
        count_d[i] = '0;
      end
      total_d      = '0;
      wrap_d       = '0;
      total_wrap_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      deb_q        <= '0;
      total_q      <= '0;
      event_q      <= '0;
      wrap_q       <= '0;
      total_wrap_q <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        dc_q[i]    <= '0;
        count_q[i] <= '0;
      end
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      deb_q        <= deb_d;
      total_q      <= total_d;
      event_q      <= event_d;
      wrap_q       <= wrap_d;
      total_wrap_q <= total_wrap_d;
      for (int i = 0; i < N_LANES; i++) begin
        dc_q[i]    <= dc_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_count_out
    assign count[g*CNT_W +: CNT_W] = count_q[g];
  end

  assign total      = total_q;
  assign lane_event = event_q;
  assign wrap       = wrap_q;
  assign total_wrap = total_wrap_q;

endmodule

// File: tb/tb_lane_car_counter.sv
// Testbench for lane_car_counter. The driver issues one input vector per
// cycle. A reference model predicts the registered outputs for that edge and
// queues them. A monitor on the falling edge pops each prediction and compares
// it with the DUT.
module tb_lane_car_counter;

  localparam int N_LANES    = 4;
  localparam int CNT_W      = 14;
  localparam int MAX_COUNT  = 100;
  localparam int DEB_CYCLES = 4;

  typedef struct packed {
    logic [N_LANES*CNT_W-1:0] count;
    logic [CNT_W-1:0]         total;
    logic [N_LANES-1:0]       ev;
    logic [N_LANES-1:0]       wrap;
    logic                     twrap;
  } exp_t;

  logic                     clk;
  logic                     rst_n;
  logic                     en;
  logic                     clr;
  logic [N_LANES-1:0]       detector;
  logic [N_LANES*CNT_W-1:0] count;
  logic [CNT_W-1:0]         total;
  logic [N_LANES-1:0]       lane_event;
  logic [N_LANES-1:0]       wrap;
  logic                     total_wrap;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q [$];
  exp_t mon_x;

  // Reference model state.
  bit   m_s1  [N_LANES];
  bit   m_s2  [N_LANES];
  bit   m_deb [N_LANES];
  bit   hist  [N_LANES][$];
  int   m_cnt [N_LANES];
  int   m_tot;

  lane_car_counter #(
    .N_LANES   (N_LANES),
    .CNT_W     (CNT_W),
    .MAX_COUNT (MAX_COUNT),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .detector  (detector),
    .count     (count),
    .total     (total),
    .lane_event(lane_event),
    .wrap      (wrap),
    .total_wrap(total_wrap)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Predict the outputs one clock edge produces for the given inputs.
  // Debounce rule: deb flips when the last DEB_CYCLES synchronised samples
  // taken since the previous flip all differ from deb.
  task automatic model_edge(input logic r, input logic e, input logic c, input logic [N_LANES-1:0] d);
    exp_t x;
    int   k;
    int   s;
    bit   alld;
    bit   rise [N_LANES];
    x = '0;
    if (!r) begin
      for (int i = 0; i < N_LANES; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_cnt[i] = 0;
        hist[i].delete();
      end
      m_tot = 0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        rise[i] = 0;
        hist[i].push_back(m_s2[i]);
        if (hist[i].size() > DEB_CYCLES) void'(hist[i].pop_front());
        alld = (hist[i].size() == DEB_CYCLES);
        foreach (hist[i][j]) if (hist[i][j] == m_deb[i]) alld = 0;
        if (alld) begin
          m_deb[i] = m_s2[i];
          rise[i]  = m_s2[i];
          hist[i].delete();
        end
        x.ev[i] = rise[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = d[i];
      end
      if (c) begin
        for (int i = 0; i < N_LANES; i++) m_cnt[i] = 0;
        m_tot = 0;
      end else if (e) begin
        k = 0;
        for (int i = 0; i < N_LANES; i++) begin
          if (rise[i]) begin
            k++;
            m_cnt[i] = (m_cnt[i] + 1) % MAX_COUNT;
            x.wrap[i] = (m_cnt[i] == 0);
          end
        end
        s = m_tot + k;
        x.twrap = (s >= MAX_COUNT);
        m_tot = s % MAX_COUNT;
      end
    end
    for (int i = 0; i < N_LANES; i++) x.count[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    x.total = CNT_W'(m_tot);
    exp_q.push_back(x);
  endtask

  // Drive one cycle of inputs shortly after the falling edge and queue the
  // outputs expected after the next rising edge.
  task automatic apply_stimulus(input logic r, input logic e, input logic c, input logic [N_LANES-1:0] d);
    @(negedge clk);
    #1;
    rst_n    = r;
    en       = e;
    clr      = c;
    detector = d;
    model_edge(r, e, c, d);
  endtask

  task automatic pulse(input logic [N_LANES-1:0] mask, input int hi, input int lo,
                       input logic e, input logic c);
    repeat (hi) apply_stimulus(1'b1, e, c, mask);
    repeat (lo) apply_stimulus(1'b1, e, c, '0);
  endtask

  // Compare each queued prediction against the DUT away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      check_output("count",      64'(count),      64'(mon_x.count));
      check_output("total",      64'(total),      64'(mon_x.total));
      check_output("event",      64'(lane_event), 64'(mon_x.ev));
      check_output("wrap",       64'(wrap),       64'(mon_x.wrap));
      check_output("total_wrap", 64'(total_wrap), 64'(mon_x.twrap));
    end
  end

  // Directed scenarios followed by a randomized stretch.
  initial begin
    logic [N_LANES-1:0] det;
    rst_n    = 1'b0;
    en       = 1'b1;
    clr      = 1'b0;
    detector = '1;

    // Reset with all detectors high, then release.
    repeat (3) apply_stimulus(1'b0, 1'b1, 1'b0, '1);
    repeat (8) apply_stimulus(1'b1, 1'b1, 1'b0, '1);
    repeat (8) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Lane 0 rises, falls and rises again.
    pulse(4'b0001, 8, 8, 1'b1, 1'b0);
    pulse(4'b0001, 8, 8, 1'b1, 1'b0);

    // Glitch on lane 1 that is too short, then a qualifying pulse.
    pulse(4'b0010, 3, 8, 1'b1, 1'b0);
    pulse(4'b0010, 6, 8, 1'b1, 1'b0);

    // Rise with en low, then with clr held across the rise edge.
    pulse(4'b0100, 8, 8, 1'b0, 1'b0);
    pulse(4'b1000, 8, 2, 1'b1, 1'b1);
    repeat (6) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Lane 2 driven past its modulus to force a lane wrap.
    repeat (MAX_COUNT + 3) pulse(4'b0100, 5, 5, 1'b1, 1'b0);

    // Simultaneous rises on all lanes, sweeping the total across its wrap.
    repeat (60) pulse(4'b1111, 5, 5, 1'b1, 1'b0);

    // Randomized traffic: long-ish runs with occasional glitches, sporadic
    // en drops, clears and resets.
    det = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N_LANES; i++) begin
        if ($urandom_range(5) == 0) det[i] = ~det[i];
      end
      apply_stimulus(($urandom_range(499) != 0), ($urandom_range(7) != 0),
                     ($urandom_range(99) == 0), det);
    end

    repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
